// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts READ/WRITE requests and completes them
// with a four-phase READY handshake after WAIT_STATES extra cycles, flagging illegal requests on ERR.
module mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  READ,
  input  logic                  WRITE,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  READY,
  output logic                  ERR
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic [DEPTH_LOG2-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_rd, r_wr, r_bad;
  logic                    w_req, w_bad, w_enter_resp, w_mem_we;
  logic [DEPTH_LOG2-1:0]   w_c_addr;
  logic [DATA_WIDTH-1:0]   w_c_wdata;
  logic                    w_c_rd, w_c_wr, w_c_bad;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  assign w_req = READ | WRITE;
  assign w_bad = (READ & WRITE) | ((ADDR >> DEPTH_LOG2) != '0);

  // With zero wait states RESP is entered on the accept edge, so commit from the live inputs.
  assign w_c_addr  = (r_state == S_IDLE) ? ADDR[DEPTH_LOG2-1:0] : r_addr;
  assign w_c_wdata = (r_state == S_IDLE) ? DATA_IN : r_wdata;
  assign w_c_rd    = (r_state == S_IDLE) ? READ    : r_rd;
  assign w_c_wr    = (r_state == S_IDLE) ? WRITE   : r_wr;
  assign w_c_bad   = (r_state == S_IDLE) ? w_bad   : r_bad;
  assign w_mem_we  = w_enter_resp & w_c_wr & ~w_c_bad & RST;

  // Next-state and wait counter
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_cnt_next = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (!w_req) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_bad    <= 1'b0;
      DATA_OUT <= '0;
      READY    <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      READY   <= (w_next == S_RESP);
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= ADDR[DEPTH_LOG2-1:0];
        r_wdata <= DATA_IN;
        r_rd    <= READ;
        r_wr    <= WRITE;
        r_bad   <= w_bad;
      end
      if (w_enter_resp) begin
        ERR <= w_c_bad;
        if (w_c_rd) DATA_OUT <= w_c_bad ? '0 : r_mem[w_c_addr];
      end else if (w_next == S_IDLE) begin
        ERR <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[w_c_addr] <= w_c_wdata;
  end

endmodule
